keypad_decoder: RTL and testbench
=================================

# keypad_decoder

Consumes the `cur_key`/`strobe` stream produced by the keypad scanner and turns key presses into ASCII letters using multi-tap entry (phone layout, 2=ABC … 9=WXYZ). It holds one pending letter for display and submits it on `#`, presenting it through a valid/ready handshake to the downstream game/transmit logic. `*` clears the pending letter.

## Interface
- `TAP_TIMEOUT`, default 12_000_000: cycles after a tap within which the same key advances the letter.
- `clk`  in  1  system clock.
- `nRst`  in  1  asynchronous, active-low reset.
- `strobe`  in  1  one-cycle key-press pulse from the scanner.
- `cur_key`  in  8  `{row[3:0], col[3:0]}`; row one-hot active-high, col one-hot active-low; 0 = no key.
- `letter_ready`  in  1  downstream accepts `letter` this cycle.
- `letter`  out  8  submitted ASCII letter (`"A"`–`"Z"`), stable while `letter_valid`.
- `letter_valid`  out  1  submitted letter available.
- `pending_letter`  out  8  ASCII letter being composed; 8'h00 when none.

## Operation
- Key map: row bit3 = top row, col bit3 low = leftmost column. Layout is `1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D`. Example codes: `2`=8'h8B, `7`=8'h27, `9`=8'h2D, `*`=8'h17, `#`=8'h1D, `A`=8'h8E.
- `cur_key` is sampled only in the cycle `strobe`=1.
  - Codes that are not exactly one row bit plus one column zero are ignored.
  - Keys `0`, `1`, and `A`–`D` are ignored.
- States: IDLE, PENDING, SUBMIT.
- **IDLE**
  - Letter key → PENDING, `pending_letter` = first letter of the key, tap index = 0, timer cleared.
  - `#` and `*` are ignored.
- **PENDING**
  - Same key with timer < `TAP_TIMEOUT`: tap index advances modulo the key's letter count (3, or 4 for 7/9). Timer is cleared.
  - Same key with timer ≥ `TAP_TIMEOUT`: restart at the first letter. Timer is cleared.
  - Different letter key: replaces pending with that key's first letter.
  - `*`: `pending_letter` = 0 → IDLE.
  - `#`: `letter` ← `pending_letter`, `letter_valid` = 1, `pending_letter` = 0 → SUBMIT.
  - Timer increments each cycle and saturates at `TAP_TIMEOUT`.
- **SUBMIT**
  - On `letter_valid && letter_ready`: `letter_valid` = 0 → IDLE.
  - All strobes in SUBMIT are dropped, including one coinciding with the accepting ready.
- `letter` keeps its last value after acceptance. Only `letter_valid` qualifies it.

## Timing
- Reset (async assert): state IDLE, `letter`=0, `letter_valid`=0, `pending_letter`=0, tap index 0, timer 0.
- All outputs are registered. A strobe at cycle N updates `pending_letter`/`letter_valid` at cycle N+1.
- Handshake: `letter_valid` may rise without `letter_ready`. It never drops before acceptance. `letter` does not change while `letter_valid`=1. Acceptance at edge N leaves `letter_valid`=0 at N+1. A new submit needs at least one IDLE/PENDING strobe, so back-to-back letters are spaced by at least 2 cycles.
- Timer boundary: an advancing tap must arrive with timer ≤ `TAP_TIMEOUT`-1. A tap exactly at saturation restarts.
- Reset mid-SUBMIT discards the unaccepted letter.

## Structure
- `keypad_pkg` contains:
  - key code localparams;
  - state enum `keypad_state_t`;
  - key enum `key_t` (K0–K9, KA–KD, KSTAR, KHASH, KNONE);
  - function `letter_of(key_t, idx)` returning ASCII;
  - function `letter_count(key_t)`.
- Sub-module `keypad_key_decode` (combinational): `cur_key` → `key_t`, with KNONE for invalid codes. The FSM, tap index, and timer live in `keypad_decoder`.

## Test plan
- `2` pressed 3× at 100-cycle spacing → `pending_letter` `"A"`, `"B"`, `"C"`. A 4th press → `"A"` (wrap). Press `9` 4× → `"Z"`.
- `7` once, then `7` again after `TAP_TIMEOUT`+5 cycles (TAP_TIMEOUT=50 in sim) → `"P"`, then `"P"` (restart, not `"Q"`).
- `8`, `8`, `#` with `letter_ready`=0 for 10 cycles → `letter_valid`=1, `letter`=`"U"`, stable 10 cycles, `pending_letter`=0. Ready pulse → valid clears next cycle.
- In SUBMIT, strobe `3` coincident with ready → `3` dropped, IDLE, `pending_letter`=0.
- `5` then `*` → `pending_letter` 0. Then `#` alone → no `letter_valid`. `A`, `0`, 8'hFF, and 8'h00 strobes → no change.
- Assert `nRst` low during PENDING and during SUBMIT → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the multi-tap keypad decoder.
// Contents: raw scanner key codes, decoder FSM state type, logical key type,
// and helper functions mapping a letter key and tap index to ASCII.
package keypad_pkg;

    // Raw scanner codes {row[3:0] one-hot high, col[3:0] one-hot low}.
    // Row bit3 is the top row, col bit3 low is the leftmost column.
    localparam logic [7:0] KEY_CODE_1    = 8'h87;
    localparam logic [7:0] KEY_CODE_2    = 8'h8B;
    localparam logic [7:0] KEY_CODE_3    = 8'h8D;
    localparam logic [7:0] KEY_CODE_A    = 8'h8E;
    localparam logic [7:0] KEY_CODE_4    = 8'h47;
    localparam logic [7:0] KEY_CODE_5    = 8'h4B;
    localparam logic [7:0] KEY_CODE_6    = 8'h4D;
    localparam logic [7:0] KEY_CODE_B    = 8'h4E;
    localparam logic [7:0] KEY_CODE_7    = 8'h27;
    localparam logic [7:0] KEY_CODE_8    = 8'h2B;
    localparam logic [7:0] KEY_CODE_9    = 8'h2D;
    localparam logic [7:0] KEY_CODE_C    = 8'h2E;
    localparam logic [7:0] KEY_CODE_STAR = 8'h17;
    localparam logic [7:0] KEY_CODE_0    = 8'h1B;
    localparam logic [7:0] KEY_CODE_HASH = 8'h1D;
    localparam logic [7:0] KEY_CODE_D    = 8'h1E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SUBMIT  = 2'd2
    } keypad_state_t;

    typedef enum logic [4:0] {
        K0    = 5'd0,
        K1    = 5'd1,
        K2    = 5'd2,
        K3    = 5'd3,
        K4    = 5'd4,
        K5    = 5'd5,
        K6    = 5'd6,
        K7    = 5'd7,
        K8    = 5'd8,
        K9    = 5'd9,
        KA    = 5'd10,
        KB    = 5'd11,
        KC    = 5'd12,
        KD    = 5'd13,
        KSTAR = 5'd14,
        KHASH = 5'd15,
        KNONE = 5'd16
    } key_t;

    // True for the keys that carry letters (2..9).
    function automatic logic is_letter_key(input key_t key);
        logic r;
        case (key)
            K2, K3, K4, K5, K6, K7, K8, K9: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Number of letters on a key: 4 for 7 and 9, 3 for other letter keys.
    function automatic logic [2:0] letter_count(input key_t key);
        logic [2:0] r;
        case (key)
            K7, K9:                 r = 3'd4;
            K2, K3, K4, K5, K6, K8: r = 3'd3;
            default:                r = 3'd0;
        endcase
        return r;
    endfunction

    // ASCII letter for a key at a tap index; 8'h00 for non-letter keys.
    // Letters are contiguous in ASCII, so base + index covers every key.
    function automatic logic [7:0] letter_of(input key_t key, input logic [1:0] idx);
        logic [7:0] base;
        logic [7:0] r;
        case (key)
            K2:      base = 8'h41; // A
            K3:      base = 8'h44; // D
            K4:      base = 8'h47; // G
            K5:      base = 8'h4A; // J
            K6:      base = 8'h4D; // M
            K7:      base = 8'h50; // P
            K8:      base = 8'h54; // T
            K9:      base = 8'h57; // W
            default: base = 8'h00;
        endcase
        if (base == 8'h00) begin
            r = 8'h00;
        end else begin
            r = base + {6'b000000, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Combinational translation of a raw scanner code into a logical key.
// Ports:
//   cur_key  in  8  {row one-hot high, col one-hot low}
//   key      out    decoded key_t, KNONE for any code that is not exactly
//                   one row bit plus one column zero
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [7:0] cur_key,
    output key_t       key
);

    // Exact match against the sixteen legal codes; anything else is KNONE.
    always_comb begin
        key = KNONE;
        case (cur_key)
            KEY_CODE_0:    key = K0;
            KEY_CODE_1:    key = K1;
            KEY_CODE_2:    key = K2;
            KEY_CODE_3:    key = K3;
            KEY_CODE_4:    key = K4;
            KEY_CODE_5:    key = K5;
            KEY_CODE_6:    key = K6;
            KEY_CODE_7:    key = K7;
            KEY_CODE_8:    key = K8;
            KEY_CODE_9:    key = K9;
            KEY_CODE_A:    key = KA;
            KEY_CODE_B:    key = KB;
            KEY_CODE_C:    key = KC;
            KEY_CODE_D:    key = KD;
            KEY_CODE_STAR: key = KSTAR;
            KEY_CODE_HASH: key = KHASH;
            default:       key = KNONE;
        endcase
    end

endmodule

// File: rtl/keypad_decoder.sv
// Multi-tap keypad decoder: composes one pending ASCII letter from repeated
// taps of keys 2..9, clears it on '*', and submits it on '#' through a
// valid/ready handshake.
// Ports:
//   clk            in   system clock
//   nRst           in   asynchronous active-low reset
//   strobe         in   one-cycle key-press pulse; cur_key sampled only then
//   cur_key        in   8  raw scanner code
//   letter_ready   in   downstream accepts letter this cycle
//   letter         out  8  submitted ASCII letter, qualified by letter_valid
//   letter_valid   out  submitted letter available
//   pending_letter out  8  letter being composed, 8'h00 when none
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned TAP_TIMEOUT = 12_000_000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       strobe,
    input  logic [7:0] cur_key,
    input  logic       letter_ready,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic [7:0] pending_letter
);

    localparam int unsigned TW = $clog2(TAP_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TAP_TIMEOUT);

    key_t            key_s;
    keypad_state_t   state_q, state_d;
    key_t            last_key_q, last_key_d;
    logic [1:0]      tap_q, tap_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      pending_q, pending_d;
    logic [7:0]      letter_q, letter_d;
    logic            valid_q, valid_d;
    logic [1:0]      tap_next_s;

    keypad_key_decode u_key_decode (
        .cur_key (cur_key),
        .key     (key_s)
    );

    // Tap index for a letter-key strobe while a letter is pending: advance
    // (with wrap) only for the same key arriving before the timer saturates.
    always_comb begin
        tap_next_s = 2'd0;
        if ((key_s == last_key_q) && (timer_q < TIMEOUT_C)) begin
            if (({1'b0, tap_q} + 3'd1) >= letter_count(key_s)) begin
                tap_next_s = 2'd0;
            end else begin
                tap_next_s = tap_q + 2'd1;
            end
        end else begin
            tap_next_s = 2'd0;
        end
    end

    // Next-state and output logic of the IDLE/PENDING/SUBMIT machine.
    always_comb begin
        state_d    = state_q;
        last_key_d = last_key_q;
        tap_d      = tap_q;
        pending_d  = pending_q;
        letter_d   = letter_q;
        valid_d    = valid_q;
        timer_d    = TW'(0);

        case (state_q)
            ST_IDLE: begin
                if (strobe && is_letter_key(key_s)) begin
                    state_d    = ST_PENDING;
                    last_key_d = key_s;
                    tap_d      = 2'd0;
                    pending_d  = letter_of(key_s, 2'd0);
                    timer_d    = TW'(0);
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_PENDING: begin
                // Saturating tap timer; any accepted key below clears it.
                if (timer_q < TIMEOUT_C) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end

                if (strobe && (key_s == KSTAR)) begin
                    state_d   = ST_IDLE;
                    pending_d = 8'h00;
                    tap_d     = 2'd0;
                    timer_d   = TW'(0);
                end else if (strobe && (key_s == KHASH)) begin
                    state_d   = ST_SUBMIT;
                    letter_d  = pending_q;
                    valid_d   = 1'b1;
                    pending_d = 8'h00;
                    tap_d     = 2'd0;
                    timer_d   = TW'(0);
                end else if (strobe && is_letter_key(key_s)) begin
                    last_key_d = key_s;
                    tap_d      = tap_next_s;
                    pending_d  = letter_of(key_s, tap_next_s);
                    timer_d    = TW'(0);
                end else begin
                    state_d    = ST_PENDING;
                end
            end

            ST_SUBMIT: begin
                // Strobes are dropped here, even one coinciding with ready.
                if (valid_q && letter_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_SUBMIT;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                pending_d = 8'h00;
                valid_d   = 1'b0;
                tap_d     = 2'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            last_key_q <= KNONE;
            tap_q      <= 2'd0;
            timer_q    <= TW'(0);
            pending_q  <= 8'h00;
            letter_q   <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_key_q <= last_key_d;
            tap_q      <= tap_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            letter_q   <= letter_d;
            valid_q    <= valid_d;
        end
    end

    assign letter         = letter_q;
    assign letter_valid   = valid_q;
    assign pending_letter = pending_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed self-checking bench for keypad_decoder (TAP_TIMEOUT = 50).
module tb_keypad_decoder;

    localparam int unsigned TAP_TIMEOUT = 50;

    logic       clk;
    logic       nRst;
    logic       strobe;
    logic [7:0] cur_key;
    logic       letter_ready;
    logic [7:0] letter;
    logic       letter_valid;
    logic [7:0] pending_letter;

    int n_cmp;
    int n_err;

    keypad_decoder #(.TAP_TIMEOUT(TAP_TIMEOUT)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .strobe         (strobe),
        .cur_key        (cur_key),
        .letter_ready   (letter_ready),
        .letter         (letter),
        .letter_valid   (letter_valid),
        .pending_letter (pending_letter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns on the falling edge after the sampling edge.
    task automatic press(input logic [7:0] code);
        @(negedge clk);
        cur_key = code;
        strobe  = 1'b1;
        @(negedge clk);
        strobe  = 1'b0;
        cur_key = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        nRst         = 1'b0;
        strobe       = 1'b0;
        cur_key      = 8'h00;
        letter_ready = 1'b0;

        // Reset state
        idle(3);
        check_value("rst_letter",  {24'd0, letter}, 32'h00);
        check_value("rst_valid",   {31'd0, letter_valid}, 32'h0);
        check_value("rst_pending", {24'd0, pending_letter}, 32'h00);
        nRst = 1'b1;
        idle(2);

        // Multi-tap on 2 with wrap, then 9 through all four letters
        press(8'h8B); check_value("2x1", {24'd0, pending_letter}, 32'h41);
        idle(10);
        press(8'h8B); check_value("2x2", {24'd0, pending_letter}, 32'h42);
        idle(10);
        press(8'h8B); check_value("2x3", {24'd0, pending_letter}, 32'h43);
        idle(10);
        press(8'h8B); check_value("2x4_wrap", {24'd0, pending_letter}, 32'h41);
        press(8'h2D); check_value("9x1", {24'd0, pending_letter}, 32'h57);
        press(8'h2D);
        press(8'h2D);
        press(8'h2D); check_value("9x4", {24'd0, pending_letter}, 32'h5A);
        press(8'h17); check_value("star_clear", {24'd0, pending_letter}, 32'h00);

        // Timer boundary: tap seen with timer 49 advances, timer 50 restarts
        press(8'h27); check_value("7x1", {24'd0, pending_letter}, 32'h50);
        idle(48);
        press(8'h27); check_value("7_t49_adv", {24'd0, pending_letter}, 32'h51);
        idle(49);
        press(8'h27); check_value("7_t50_restart", {24'd0, pending_letter}, 32'h50);
        idle(TAP_TIMEOUT + 5);
        press(8'h27); check_value("7_late_restart", {24'd0, pending_letter}, 32'h50);
        press(8'h17);

        // 8,8,# with ready held low: letter held stable
        press(8'h2B);
        press(8'h2B); check_value("8x2", {24'd0, pending_letter}, 32'h55);
        press(8'h1D);
        check_value("sub_valid", {31'd0, letter_valid}, 32'h1);
        check_value("sub_pending", {24'd0, pending_letter}, 32'h00);
        for (int i = 0; i < 10; i++) begin
            check_value("hold_valid", {31'd0, letter_valid}, 32'h1);
            check_value("hold_letter", {24'd0, letter}, 32'h55);
            @(negedge clk);
        end
        letter_ready = 1'b1;
        @(negedge clk);
        letter_ready = 1'b0;
        check_value("accept_valid", {31'd0, letter_valid}, 32'h0);
        check_value("accept_letter_kept", {24'd0, letter}, 32'h55);

        // Strobe coinciding with the accepting ready is dropped
        press(8'h8D); check_value("3x1", {24'd0, pending_letter}, 32'h44);
        press(8'h1D); check_value("sub2_valid", {31'd0, letter_valid}, 32'h1);
        @(negedge clk);
        letter_ready = 1'b1;
        strobe       = 1'b1;
        cur_key      = 8'h8D;
        @(negedge clk);
        letter_ready = 1'b0;
        strobe       = 1'b0;
        cur_key      = 8'h00;
        check_value("drop_valid", {31'd0, letter_valid}, 32'h0);
        check_value("drop_pending", {24'd0, pending_letter}, 32'h00);
        check_value("drop_letter", {24'd0, letter}, 32'h44);
        press(8'h1D); check_value("idle_hash", {31'd0, letter_valid}, 32'h0);

        // '*' clears, lone '#' and ignored codes do nothing
        press(8'h4B); check_value("5x1", {24'd0, pending_letter}, 32'h4A);
        press(8'h17); check_value("5_star", {24'd0, pending_letter}, 32'h00);
        press(8'h1D); check_value("lone_hash", {31'd0, letter_valid}, 32'h0);
        press(8'h4B);
        press(8'h8E); check_value("ign_A", {24'd0, pending_letter}, 32'h4A);
        press(8'h1B); check_value("ign_0", {24'd0, pending_letter}, 32'h4A);
        press(8'hFF); check_value("ign_FF", {24'd0, pending_letter}, 32'h4A);
        press(8'h00); check_value("ign_00", {24'd0, pending_letter}, 32'h4A);
        press(8'hCB); check_value("ign_2rows", {24'd0, pending_letter}, 32'h4A);
        press(8'h87); check_value("ign_1", {24'd0, pending_letter}, 32'h4A);
        press(8'h17);
        press(8'h8E); check_value("idle_ign_A", {24'd0, pending_letter}, 32'h00);

        // Reset during PENDING
        press(8'h4B);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        check_value("rstp_pending", {24'd0, pending_letter}, 32'h00);
        @(negedge clk);
        nRst = 1'b1;
        press(8'h8B); check_value("rstp_idle", {24'd0, pending_letter}, 32'h41);

        // Reset during SUBMIT discards the letter
        press(8'h1D); check_value("sub3_valid", {31'd0, letter_valid}, 32'h1);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        check_value("rsts_valid", {31'd0, letter_valid}, 32'h0);
        check_value("rsts_letter", {24'd0, letter}, 32'h00);
        @(negedge clk);
        nRst = 1'b1;
        press(8'h1D); check_value("rsts_idle_hash", {31'd0, letter_valid}, 32'h0);
        press(8'h47); check_value("rsts_4", {24'd0, pending_letter}, 32'h47);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
